// File: rtl/jtag_axi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jtag_axi_arbiter (with amba_axi_pkg)
// Description : 2:1 AXI4 arbiter sharing one downstream master port between
//               the JTAG-AXI bridge (m0) and a second requester (m1). Write and
//               read paths are arbitrated independently, one outstanding
//               transaction per path.
// Revision    : 1.0 - initial release
// ============================================================================

package amba_axi_pkg;

   localparam int AXI_ID_W   = 4;
   localparam int AXI_ADDR_W = 32;
   localparam int AXI_DATA_W = 32;
   localparam int AXI_USER_W = 1;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   typedef struct packed {
      logic [AXI_ID_W-1:0]     awid;
      logic [AXI_ADDR_W-1:0]   awaddr;
      logic [7:0]              awlen;
      logic [2:0]              awsize;
      logic [1:0]              awburst;
      logic [AXI_USER_W-1:0]   awuser;
      logic                    awvalid;
      logic [AXI_DATA_W-1:0]   wdata;
      logic [AXI_DATA_W/8-1:0] wstrb;
      logic                    wlast;
      logic [AXI_USER_W-1:0]   wuser;
      logic                    wvalid;
      logic                    bready;
      logic [AXI_ID_W-1:0]     arid;
      logic [AXI_ADDR_W-1:0]   araddr;
      logic [7:0]              arlen;
      logic [2:0]              arsize;
      logic [1:0]              arburst;
      logic [AXI_USER_W-1:0]   aruser;
      logic                    arvalid;
      logic                    rready;
   } s_axi_mosi_t;

   typedef struct packed {
      logic                    awready;
      logic                    wready;
      logic [AXI_ID_W-1:0]     bid;
      logic [1:0]              bresp;
      logic [AXI_USER_W-1:0]   buser;
      logic                    bvalid;
      logic                    arready;
      logic [AXI_ID_W-1:0]     rid;
      logic [AXI_DATA_W-1:0]   rdata;
      logic [1:0]              rresp;
      logic                    rlast;
      logic [AXI_USER_W-1:0]   ruser;
      logic                    rvalid;
   } s_axi_miso_t;

endpackage

module jtag_axi_arbiter
   import amba_axi_pkg::*;
#(
   parameter int   ARB_MODE  = 0,
   parameter logic M0_ID_TAG = 1'b0
)(
   input  logic        clk_axi,
   input  logic        ares_axi,
   input  s_axi_mosi_t m0_mosi_i,
   output s_axi_miso_t m0_miso_o,
   input  s_axi_mosi_t m1_mosi_i,
   output s_axi_miso_t m1_miso_o,
   output s_axi_mosi_t s_mosi_o,
   input  s_axi_miso_t s_miso_i,
   output logic [1:0]  wr_owner_o,
   output logic [1:0]  rd_owner_o
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_AW   = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_DATA = 2'd2
   } rd_state_e;

   // Bits of the request bundle that belong to the write path; the rest
   // belong to the read path and follow the read owner.
   localparam s_axi_mosi_t c_wr_fields = '{
      awid: '1, awaddr: '1, awlen: '1, awsize: '1, awburst: '1, awuser: '1,
      awvalid: 1'b1, wdata: '1, wstrb: '1, wlast: 1'b1, wuser: '1,
      wvalid: 1'b1, bready: 1'b1, default: '0
   };

   // Select 0 = m0, 1 = m1. On a tie, fixed priority favours m0, round-robin
   // favours the requester named by the pointer.
   function automatic logic f_pick(input logic req0, input logic req1, input logic ptr);
      if (req0 && req1) begin
         return (ARB_MODE == 1) ? 1'b0 : ptr;
      end
      return req1;
   endfunction

   wr_state_e   wr_state_q, wr_state_d;
   rd_state_e   rd_state_q, rd_state_d;
   logic        wr_sel_q, wr_sel_d;
   logic        rd_sel_q, rd_sel_d;
   logic        wr_rr_q, wr_rr_d;
   logic        rd_rr_q, rd_rr_d;
   logic        aw_done_q, aw_done_d;
   logic        w_done_q, w_done_d;
   logic        wid_msb_q, wid_msb_d;
   logic        rid_msb_q, rid_msb_d;

   s_axi_mosi_t w_wr_mosi;
   s_axi_mosi_t w_rd_mosi;
   logic        w_wr_tag;
   logic        w_rd_tag;
   logic        w_wr_busy;
   logic        w_rd_busy;

   logic        w_s_awvalid, w_s_wvalid, w_s_bready;
   logic        w_up_awready, w_up_wready, w_up_bvalid;
   logic        w_aw_hs, w_wl_hs;
   logic        w_s_arvalid, w_s_rready;
   logic        w_up_arready, w_up_rvalid;

   // Payload and ID tag follow the registered owner of each path.
   assign w_wr_mosi  = wr_sel_q ? m1_mosi_i : m0_mosi_i;
   assign w_rd_mosi  = rd_sel_q ? m1_mosi_i : m0_mosi_i;
   assign w_wr_tag   = wr_sel_q ? ~M0_ID_TAG : M0_ID_TAG;
   assign w_rd_tag   = rd_sel_q ? ~M0_ID_TAG : M0_ID_TAG;
   assign w_wr_busy  = (wr_state_q != W_IDLE);
   assign w_rd_busy  = (rd_state_q != R_IDLE);
   assign wr_owner_o = w_wr_busy ? (wr_sel_q ? 2'b10 : 2'b01) : 2'b00;
   assign rd_owner_o = w_rd_busy ? (rd_sel_q ? 2'b10 : 2'b01) : 2'b00;

   // State registers for both paths.
   always_ff @(posedge clk_axi or negedge ares_axi) begin
      if (!ares_axi) begin
         wr_state_q <= W_IDLE;
         rd_state_q <= R_IDLE;
         wr_sel_q   <= 1'b0;
         rd_sel_q   <= 1'b0;
         wr_rr_q    <= 1'b0;
         rd_rr_q    <= 1'b0;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         wid_msb_q  <= 1'b0;
         rid_msb_q  <= 1'b0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         wr_sel_q   <= wr_sel_d;
         rd_sel_q   <= rd_sel_d;
         wr_rr_q    <= wr_rr_d;
         rd_rr_q    <= rd_rr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
         wid_msb_q  <= wid_msb_d;
         rid_msb_q  <= rid_msb_d;
      end
   end

   // Write path: arbitration, AW/W pass-through with sticky completion flags, B routing.
   always_comb begin
      wr_state_d   = wr_state_q;
      wr_sel_d     = wr_sel_q;
      wr_rr_d      = wr_rr_q;
      aw_done_d    = aw_done_q;
      w_done_d     = w_done_q;
      wid_msb_d    = wid_msb_q;
      w_s_awvalid  = 1'b0;
      w_s_wvalid   = 1'b0;
      w_s_bready   = 1'b0;
      w_up_awready = 1'b0;
      w_up_wready  = 1'b0;
      w_up_bvalid  = 1'b0;
      w_aw_hs      = 1'b0;
      w_wl_hs      = 1'b0;
      case (wr_state_q)
         W_IDLE: begin
            if (m0_mosi_i.awvalid || m1_mosi_i.awvalid) begin
               wr_sel_d   = f_pick(m0_mosi_i.awvalid, m1_mosi_i.awvalid, wr_rr_q);
               wr_state_d = W_AW;
            end
         end
         W_AW: begin
            // AW and W run side by side so slaves that wait for both valids make progress.
            w_s_awvalid  = w_wr_mosi.awvalid & ~aw_done_q;
            w_up_awready = s_miso_i.awready & ~aw_done_q;
            w_s_wvalid   = w_wr_mosi.wvalid & ~w_done_q;
            w_up_wready  = s_miso_i.wready & ~w_done_q;
            w_aw_hs      = w_s_awvalid & s_miso_i.awready;
            w_wl_hs      = w_s_wvalid & s_miso_i.wready & w_wr_mosi.wlast;
            if (w_aw_hs) begin
               aw_done_d = 1'b1;
               wid_msb_d = w_wr_mosi.awid[AXI_ID_W-1];
            end
            if (w_wl_hs) begin
               w_done_d = 1'b1;
            end
            if ((aw_done_q || w_aw_hs) && (w_done_q || w_wl_hs)) begin
               wr_state_d = W_RESP;
            end
         end
         W_RESP: begin
            w_up_bvalid = s_miso_i.bvalid;
            w_s_bready  = w_wr_mosi.bready;
            if (s_miso_i.bvalid && w_wr_mosi.bready) begin
               wr_state_d = W_IDLE;
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               wr_rr_d    = ~wr_sel_q;
            end
         end
         default: begin
            wr_state_d = W_IDLE;
         end
      endcase
   end

   // Read path: arbitration, AR pass-through, R burst routing until rlast.
   always_comb begin
      rd_state_d   = rd_state_q;
      rd_sel_d     = rd_sel_q;
      rd_rr_d      = rd_rr_q;
      rid_msb_d    = rid_msb_q;
      w_s_arvalid  = 1'b0;
      w_s_rready   = 1'b0;
      w_up_arready = 1'b0;
      w_up_rvalid  = 1'b0;
      case (rd_state_q)
         R_IDLE: begin
            if (m0_mosi_i.arvalid || m1_mosi_i.arvalid) begin
               rd_sel_d   = f_pick(m0_mosi_i.arvalid, m1_mosi_i.arvalid, rd_rr_q);
               rd_state_d = R_AR;
            end
         end
         R_AR: begin
            w_s_arvalid  = w_rd_mosi.arvalid;
            w_up_arready = s_miso_i.arready;
            if (w_rd_mosi.arvalid && s_miso_i.arready) begin
               rid_msb_d  = w_rd_mosi.arid[AXI_ID_W-1];
               rd_state_d = R_DATA;
            end
         end
         R_DATA: begin
            w_up_rvalid = s_miso_i.rvalid;
            w_s_rready  = w_rd_mosi.rready;
            if (s_miso_i.rvalid && w_rd_mosi.rready && s_miso_i.rlast) begin
               rd_state_d = R_IDLE;
               rd_rr_d    = ~rd_sel_q;
            end
         end
         default: begin
            rd_state_d = R_IDLE;
         end
      endcase
   end

   // Output muxing: downstream request from the owners, responses routed back with the ID MSB restored.
   always_comb begin
      s_mosi_o         = s_axi_mosi_t'((w_wr_mosi & c_wr_fields) | (w_rd_mosi & ~c_wr_fields));
      s_mosi_o.awid    = {w_wr_tag, w_wr_mosi.awid[AXI_ID_W-2:0]};
      s_mosi_o.arid    = {w_rd_tag, w_rd_mosi.arid[AXI_ID_W-2:0]};
      s_mosi_o.awvalid = w_s_awvalid;
      s_mosi_o.wvalid  = w_s_wvalid;
      s_mosi_o.bready  = w_s_bready;
      s_mosi_o.arvalid = w_s_arvalid;
      s_mosi_o.rready  = w_s_rready;

      m0_miso_o         = s_miso_i;
      m0_miso_o.awready = 1'b0;
      m0_miso_o.wready  = 1'b0;
      m0_miso_o.bvalid  = 1'b0;
      m0_miso_o.arready = 1'b0;
      m0_miso_o.rvalid  = 1'b0;
      m0_miso_o.bid     = {wid_msb_q, s_miso_i.bid[AXI_ID_W-2:0]};
      m0_miso_o.rid     = {rid_msb_q, s_miso_i.rid[AXI_ID_W-2:0]};
      m1_miso_o         = m0_miso_o;

      if (w_wr_busy) begin
         if (wr_sel_q) begin
            m1_miso_o.awready = w_up_awready;
            m1_miso_o.wready  = w_up_wready;
            m1_miso_o.bvalid  = w_up_bvalid;
         end else begin
            m0_miso_o.awready = w_up_awready;
            m0_miso_o.wready  = w_up_wready;
            m0_miso_o.bvalid  = w_up_bvalid;
         end
      end
      if (w_rd_busy) begin
         if (rd_sel_q) begin
            m1_miso_o.arready = w_up_arready;
            m1_miso_o.rvalid  = w_up_rvalid;
         end else begin
            m0_miso_o.arready = w_up_arready;
            m0_miso_o.rvalid  = w_up_rvalid;
         end
      end
   end

endmodule
`default_nettype wire
